// File: rtl/pipeif_fetch.sv
// pipeif_fetch: instruction fetch front end feeding the IF/ID register.
// Owns the fetch PC and runs a req/ack handshake to instruction memory.
// A QDEPTH-entry prefetch queue (QDEPTH = 2 or 4) absorbs IF/ID stalls.
// A redirect from ID flushes the queue. It also flushes any fetch that is
// still in flight.
//
// Handshake: imem_req/imem_addr are held stable from the cycle imem_req rises
// until the cycle imem_ack is sampled high. imem_rdata is valid with imem_ack.
// At most one request is outstanding at any time.
//
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, an ack that
// arrives while the queue is empty is forwarded combinationally to pc4/ins.
// dbg_state exposes the FSM state: 0 = RUN, 1 = KILL.
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        install,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        dbg_state
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_RUN = 1'b0, S_KILL = 1'b1} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [31:0]   r_fpc;
  logic [31:0]   r_kill_addr;
  logic          r_started;
  logic [31:0]   r_q_pc4 [QDEPTH];
  logic [31:0]   r_q_ins [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_room;
  logic w_run_ack;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty   = (r_count == '0);
  assign w_room    = (r_count < CW'(QDEPTH));
  // Only an ack to a live request in RUN, with no redirect, carries usable data.
  assign w_run_ack = (r_state == S_RUN) & imem_req & imem_ack & ~redirect;
`ifdef FETCH_BYPASS_EN
  assign w_bypass  = w_run_ack & w_empty;
  assign w_push    = w_run_ack & ~(w_bypass & install);
`else
  assign w_bypass  = 1'b0;
  assign w_push    = w_run_ack;
`endif
  assign w_pop     = install & ~w_empty & ~redirect;
  assign dbg_state = r_state;

  // FSM state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= S_RUN;
    else       r_state <= w_next_state;
  end

  // Next state: a redirect that leaves a request un-acked must wait out its stale ack
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN:   if (redirect && imem_req && !imem_ack) w_next_state = S_KILL;
      S_KILL:  if (imem_ack) w_next_state = S_RUN;
      default: w_next_state = S_RUN;
    endcase
  end

  // FSM outputs: request (stale address while killing) and the IF/ID head view
  always_comb begin
    imem_req  = (r_state == S_KILL) | (r_started & w_room);
    imem_addr = (r_state == S_KILL) ? r_kill_addr : r_fpc;
    pc4       = 32'h0;
    ins       = 32'h0;
    if (!w_empty) begin
      pc4 = r_q_pc4[r_rd_ptr];
      ins = r_q_ins[r_rd_ptr];
    end else if (w_bypass) begin
      pc4 = r_fpc + 32'd4;
      ins = imem_rdata;
    end
  end

  // Fetch PC, start flag and the address held while a stale request drains
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_fpc       <= RESET_PC;
      r_kill_addr <= RESET_PC;
      r_started   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (redirect)       r_fpc <= target;
      else if (w_run_ack) r_fpc <= r_fpc + 32'd4;
      if (r_state == S_RUN && w_next_state == S_KILL) r_kill_addr <= r_fpc;
    end
  end

  // Prefetch queue: redirect clears it, otherwise push/pop with simultaneous support
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_pc4[i] <= 32'h0;
        r_q_ins[i] <= 32'h0;
      end
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_pc4[r_wr_ptr] <= r_fpc + 32'd4;
        r_q_ins[r_wr_ptr] <= imem_rdata;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeif_fetch.sv
// tb_pipeif_fetch: directed, table-driven bench for pipeif_fetch.
// Each vector is one clock cycle. Its inputs are driven 1ns after the rising
// edge. The outputs are compared mid-cycle, and then the clock advances.
module tb_pipeif_fetch;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic        install;
  logic        redirect;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] ins;
  logic        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        install;
    logic        redirect;
    logic [31:0] target;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc4;
    logic [31:0] e_ins;
    logic        e_kill;
  } vec_t;

  vec_t vecs [23];

  // clock / reset block
  always #5 clk = ~clk;

  pipeif_fetch #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk(clk), .clrn(clrn), .install(install), .redirect(redirect),
    .target(target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc4(pc4), .ins(ins),
    .dbg_state(dbg_state)
  );

  function automatic vec_t mk(logic i_ins, logic i_red, logic [31:0] i_tgt,
                              logic i_ack, logic [31:0] i_rd, logic x_req,
                              logic [31:0] x_addr, logic [31:0] x_pc4,
                              logic [31:0] x_ins, logic x_kill);
    vec_t v;
    v.install = i_ins; v.redirect = i_red; v.target = i_tgt;
    v.ack = i_ack; v.rdata = i_rd;
    v.e_req = x_req; v.e_addr = x_addr; v.e_pc4 = x_pc4; v.e_ins = x_ins;
    v.e_kill = x_kill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input int idx, input logic e_req, input logic [31:0] e_addr,
                            input logic [31:0] e_pc4, input logic [31:0] e_ins,
                            input logic e_kill);
    check($sformatf("v%0d req", idx),  {31'h0, imem_req},  {31'h0, e_req});
    check($sformatf("v%0d addr", idx), imem_addr, e_addr);
    check($sformatf("v%0d pc4", idx),  pc4, e_pc4);
    check($sformatf("v%0d ins", idx),  ins, e_ins);
    check($sformatf("v%0d kill", idx), {31'h0, dbg_state}, {31'h0, e_kill});
  endtask

  // driver: apply one vector, compare mid-cycle, advance one clock
  task automatic run_vec(input int idx, input vec_t v);
    install    = v.install;
    redirect   = v.redirect;
    target     = v.target;
    imem_ack   = v.ack;
    imem_rdata = v.rdata;
    #3;
    check_outs(idx, v.e_req, v.e_addr, v.e_pc4, v.e_ins, v.e_kill);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cycle-by-cycle stimulus after reset release
    //            ins red tgt            ack rdata           req addr           pc4                          ins                                kill
    vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,                      32'h0,                             0);
    vecs[1]  = mk(0, 0, 32'h0,         1, 32'h20080005,  1, 32'h0,         BYP ? 32'h4 : 32'h0,        BYP ? 32'h20080005 : 32'h0,        0);
    vecs[2]  = mk(0, 0, 32'h0,         1, 32'h11111111,  1, 32'h4,         32'h4,                      32'h20080005,                      0);
    vecs[3]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         32'h4,                      32'h20080005,                      0);
    vecs[4]  = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         32'h4,                      32'h20080005,                      0);
    vecs[5]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         32'h8,                      32'h11111111,                      0);
    vecs[6]  = mk(0, 1, 32'h100,       0, 32'h0,         1, 32'h8,         32'h8,                      32'h11111111,                      0);
    vecs[7]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         32'h0,                      32'h0,                             1);
    vecs[8]  = mk(0, 0, 32'h0,         1, 32'hDEADBEEF,  1, 32'h8,         32'h0,                      32'h0,                             1);
    vecs[9]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h100,       32'h0,                      32'h0,                             0);
    vecs[10] = mk(0, 0, 32'h0,         1, 32'h22222222,  1, 32'h100,       BYP ? 32'h104 : 32'h0,      BYP ? 32'h22222222 : 32'h0,        0);
    vecs[11] = mk(0, 1, 32'h40,        1, 32'h33333333,  1, 32'h104,       32'h104,                    32'h22222222,                      0);
    vecs[12] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h40,        32'h0,                      32'h0,                             0);
    vecs[13] = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h40,        32'h0,                      32'h0,                             0);
    vecs[14] = mk(0, 1, 32'h80,        0, 32'h0,         1, 32'h40,        32'h0,                      32'h0,                             0);
    vecs[15] = mk(0, 1, 32'hC0,        0, 32'h0,         1, 32'h40,        32'h0,                      32'h0,                             1);
    vecs[16] = mk(0, 0, 32'h0,         1, 32'h44444444,  1, 32'h40,        32'h0,                      32'h0,                             1);
    vecs[17] = mk(0, 0, 32'h0,         1, 32'h55555555,  1, 32'hC0,        BYP ? 32'hC4 : 32'h0,       BYP ? 32'h55555555 : 32'h0,        0);
    vecs[18] = mk(1, 0, 32'h0,         1, 32'h66666666,  1, 32'hC4,        32'hC4,                     32'h55555555,                      0);
    vecs[19] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'hC8,        32'hC8,                     32'h66666666,                      0);
    vecs[20] = mk(1, 1, 32'h200,       0, 32'h0,         1, 32'hC8,        32'hC8,                     32'h66666666,                      0);
    vecs[21] = mk(0, 0, 32'h0,         1, 32'h77777777,  1, 32'hC8,        32'h0,                      32'h0,                             1);
    vecs[22] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h200,       32'h0,                      32'h0,                             0);

    clrn = 1'b0; install = 1'b0; redirect = 1'b0; target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #2;
    check_outs(100, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 clrn = 1'b1;

    for (int i = 0; i < 23; i++) run_vec(i, vecs[i]);

    // reset mid-operation with a request to 0x200 outstanding
    clrn = 1'b0;
    #2;
    check_outs(200, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1 clrn = 1'b1;

    // redirect before the first request, then an ack into an empty queue with install
    run_vec(201, mk(0, 1, 32'h10, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0));
    run_vec(202, mk(1, 0, 32'h0, 1, 32'h8C220000, 1, 32'h10,
                    BYP ? 32'h14 : 32'h0, BYP ? 32'h8C220000 : 32'h0, 0));
    run_vec(203, mk(0, 0, 32'h0, 0, 32'h0, 1, 32'h14,
                    BYP ? 32'h0 : 32'h14, BYP ? 32'h0 : 32'h8C220000, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
